aud_dac_tx: RTL
===============

Name: aud_dac_tx

Overview:
- Serialises 16-bit signed PCM samples from the playback DSP path onto the WM8731 DAC serial input (AUD_DACDAT) in I2S format.
- The codec is bus master; this block is a slave to AUD_BCLK and AUD_DACLRCK.
- It is the transmit-side counterpart of the ADC capture path. It sits between the DSP sample stream and the codec pin, with a small FIFO to absorb rate mismatch between the two.

Parameters:
- SAMPLE_W, 16: sample width in bits, MSB first on the wire.
- FIFO_DEPTH, 4: sample FIFO entries; must be a power of 2 and at least 2.
- DUAL_SLOT, 1: 1 = the same sample is sent in both left and right slots; 0 = right slot drives zeros.

Ports:
- i_clk, input, 1: system clock (12 MHz codec MCLK domain).
- i_rst_n, input, 1: asynchronous active-low reset.
- i_en, input, 1: playback enable.
- i_flush, input, 1: synchronous FIFO clear (single-cycle pulse).
- i_sample, input, SAMPLE_W: sample data from the DSP.
- i_valid, input, 1: sample-present qualifier.
- o_ready, output, 1: FIFO can accept a sample.
- i_AUD_BCLK, input, 1: codec bit clock (asynchronous).
- i_AUD_DACLRCK, input, 1: codec frame clock; low = left slot.
- o_AUD_DACDAT, output, 1: serial data to the codec.
- o_level, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- o_underrun, output, 1: one-cycle pulse when a left slot starts with the FIFO empty.
- o_underrun_cnt, output, 16: saturating underrun count.

Behaviour:
- Reset values: o_AUD_DACDAT=0, o_ready=1, o_level=0, o_underrun=0, o_underrun_cnt=0. The FIFO is empty, the shift register is 0, the bit counter is 0, and the stored LRCK is 1 (so the first falling LRCK is detected).
- Synchronisation:
  - BCLK and DACLRCK each pass through 2-flop synchronisers.
  - A BCLK fall is detected as sync_q=1 and sync=0; latency is 3 i_clk cycles.
  - Requirement: BCLK high and low phases are each at least 4 i_clk cycles. The bench must violate nothing here.
- Push handshake:
  - A transfer occurs on a cycle with i_valid && o_ready.
  - o_ready = !full, combinational from the registered level.
  - i_sample is captured on the transfer cycle; the DSP holds it while i_valid && !o_ready.
- Slot state machine (IDLE, DELAY, SHIFT, PAD), evaluated only on detected BCLK falls:
  - Boundary: at any BCLK fall where synced LRCK differs from the stored value, this is the slot start F0. Update the stored LRCK, then go to DELAY. This applies from any state, so a misaligned frame resynchronises.
  - At F0, left slot (LRCK=0):
    - If i_en=1 and the FIFO is not empty: pop the head into the hold register and into the shift register.
    - If i_en=1 and the FIFO is empty: load 0, pulse o_underrun, increment o_underrun_cnt (saturating at 16'hFFFF).
    - If i_en=0: load 0 with no pop and no underrun.
  - At F0, right slot: load the hold register if DUAL_SLOT=1 and i_en=1; otherwise load 0.
  - DELAY: o_AUD_DACDAT stays 0. This is the I2S one-bit delay; the codec samples a don't-care bit on the next rise. At the next fall, go to SHIFT with cnt=SAMPLE_W.
  - SHIFT: on each fall, drive shreg[MSB], shift left, decrement cnt. When cnt reaches 0, go to PAD.
  - PAD: drive 0 until the next F0.
  - o_AUD_DACDAT changes only on detected BCLK falls, with no glitches; it is a registered output.
- i_en is sampled only at F0, so a slot in progress always completes. The FIFO contents are retained while i_en=0.
- i_flush empties the FIFO and sets level=0 in the same edge. It has priority over a push in the same cycle and does not disturb the current shift.
- FIFO corner cases:
  - Push and pop in the same cycle: the level is unchanged.
  - A pop at F0 with the FIFO empty while a push is also happening: counts as underrun; there is no bypass.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-slot: everything returns to reset values immediately, o_AUD_DACDAT=0. The next frame starts at the first LRCK falling edge seen.

Decomposition:
- Package aud_pkg:
  - SAMPLE_W localparam.
  - typedef logic signed [SAMPLE_W-1:0] sample_t.
  - enum tx_state_e {IDLE, DELAY, SHIFT, PAD}.
  - LRCK_LEFT=1'b0.
- Sub-module aud_sample_fifo: parameterised synchronous FIFO with push/pop/flush, full/empty/level. This is reused by the capture path.
- Synchronisers and edge detection stay inline.

Test Plan:
- Push 16'hA5C3 with i_en=1, then run a frame with BCLK = 8 i_clk periods. Required: left slot shows 0 (delay bit), then 1010010111000011 sampled on BCLK rises 2..17, then zeros. With DUAL_SLOT=1 the right slot repeats the same 16 bits.
- Run one frame with the FIFO empty and i_en=1. Required: o_underrun pulses once, o_underrun_cnt=1, DACDAT all zeros. A second empty frame gives o_underrun_cnt=2.
- Push 4 samples with no frames running. Required: o_level=4, o_ready=0, and a 5th i_valid is not accepted. After 1 frame: o_level=3, o_ready=1, and the first-pushed sample appears on the wire.
- Deassert i_en mid-SHIFT with sample 16'h8001. Required: the current slot finishes all 16 bits, the next left slot is zeros, o_level is unchanged, and there is no underrun pulse.
- Assert i_flush with o_level=3 in the same cycle as a valid push. Required: o_level=0 next cycle; the following left slot underruns.
- Assert i_rst_n=0 during bit 7 of a slot. Required: DACDAT=0 and all counters are 0 immediately. After release, transmission restarts cleanly at the next LRCK fall.

Source files
------------

// File: rtl/aud_pkg.sv
// rtl/aud_pkg.sv - shared types and constants for the audio DAC transmit path
package aud_pkg;
  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {IDLE, DELAY, SHIFT, PAD} tx_state_e;

  localparam logic LRCK_LEFT = 1'b0;
endpackage

// File: rtl/aud_sample_fifo.sv
// rtl/aud_sample_fifo.sv - small synchronous sample FIFO with flush and level
module aud_sample_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [W-1:0]             o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          do_push, do_pop;

  assign o_full  = (level_q == LW'(DEPTH));
  assign o_empty = (level_q == '0);
  assign o_level = level_q;
  assign o_rdata = mem_q[rd_ptr_q];

  // Flush wins over both push and pop in the same cycle.
  assign do_push = i_push && !o_full && !i_flush;
  assign do_pop  = i_pop && !o_empty && !i_flush;

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      level_q <= level_q + LW'(1);
      else if (do_pop && !do_push) level_q <= level_q - LW'(1);
    end
  end
endmodule

// File: rtl/aud_dac_tx.sv
// rtl/aud_dac_tx.sv - I2S slave transmitter feeding the codec DAC serial input
module aud_dac_tx #(
  parameter int SAMPLE_W   = aud_pkg::SAMPLE_W,
  parameter int FIFO_DEPTH = 4,
  parameter bit DUAL_SLOT  = 1'b1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_en,
  input  logic                          i_flush,
  input  logic [SAMPLE_W-1:0]           i_sample,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic                          i_AUD_BCLK,
  input  logic                          i_AUD_DACLRCK,
  output logic                          o_AUD_DACDAT,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_underrun,
  output logic [15:0]                   o_underrun_cnt
);
  import aud_pkg::*;

  localparam int CNT_W = $clog2(SAMPLE_W);

  logic                bclk_meta_q, bclk_sync_q, bclk_prev_q;
  logic                lrck_meta_q, lrck_sync_q, lrck_q;
  tx_state_e           state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [SAMPLE_W-1:0] shreg_q, hold_q;
  logic                dacdat_q, underrun_q;
  logic [15:0]         urun_cnt_q;

  logic                fifo_full, fifo_empty, push, pop;
  logic                bclk_fall, slot_start, left_start, urun;
  logic [SAMPLE_W-1:0] fifo_rdata;

  assign o_ready    = !fifo_full;
  assign push       = i_valid && o_ready;
  assign bclk_fall  = bclk_prev_q && !bclk_sync_q;
  assign slot_start = bclk_fall && (lrck_sync_q != lrck_q);
  assign left_start = slot_start && (lrck_sync_q == LRCK_LEFT);
  assign pop        = left_start && i_en && !fifo_empty;
  assign urun       = left_start && i_en && fifo_empty;

  aud_sample_fifo #(.W(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_wdata (i_sample),
    .i_pop   (pop),
    .i_flush (i_flush),
    .o_rdata (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (o_level)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bclk_meta_q <= 1'b0;
      bclk_sync_q <= 1'b0;
      bclk_prev_q <= 1'b0;
      lrck_meta_q <= 1'b1;
      lrck_sync_q <= 1'b1;
      lrck_q      <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      hold_q      <= '0;
      dacdat_q    <= 1'b0;
      underrun_q  <= 1'b0;
      urun_cnt_q  <= '0;
    end else begin
      bclk_meta_q <= i_AUD_BCLK;
      bclk_sync_q <= bclk_meta_q;
      bclk_prev_q <= bclk_sync_q;
      lrck_meta_q <= i_AUD_DACLRCK;
      lrck_sync_q <= lrck_meta_q;
      underrun_q  <= urun;
      if (urun && (urun_cnt_q != 16'hFFFF)) urun_cnt_q <= urun_cnt_q + 16'd1;

      if (bclk_fall) begin
        if (slot_start) begin
          // A frame-clock change restarts the slot from any state.
          lrck_q   <= lrck_sync_q;
          state_q  <= DELAY;
          dacdat_q <= 1'b0;
          if (lrck_sync_q == LRCK_LEFT) begin
            shreg_q <= pop ? fifo_rdata : '0;
            hold_q  <= pop ? fifo_rdata : '0;
          end else begin
            shreg_q <= (DUAL_SLOT && i_en) ? hold_q : '0;
          end
        end else begin
          case (state_q)
            IDLE, PAD: dacdat_q <= 1'b0;
            DELAY: begin
              dacdat_q <= shreg_q[SAMPLE_W-1];
              shreg_q  <= {shreg_q[SAMPLE_W-2:0], 1'b0};
              cnt_q    <= CNT_W'(SAMPLE_W - 1);
              state_q  <= SHIFT;
            end
            SHIFT: begin
              if (cnt_q == '0) begin
                dacdat_q <= 1'b0;
                state_q  <= PAD;
              end else begin
                dacdat_q <= shreg_q[SAMPLE_W-1];
                shreg_q  <= {shreg_q[SAMPLE_W-2:0], 1'b0};
                cnt_q    <= cnt_q - CNT_W'(1);
              end
            end
          endcase
        end
      end
    end
  end

  assign o_AUD_DACDAT   = dacdat_q;
  assign o_underrun     = underrun_q;
  assign o_underrun_cnt = urun_cnt_q;
endmodule
